// File: rtl/afifo_wr_ctrl_if.sv
// Write-side bus of the asynchronous FIFO: request/clear inputs, synchronized read
// pointer, and the RAM write port plus status flags produced by the write controller.
interface afifo_wr_ctrl_if #(
   parameter int WIDTH_D = 5
);
   logic               wr_en;
   logic [WIDTH_D:0]   rd_gray_syn;
   logic               wr_ovf_clr;
   logic [WIDTH_D-1:0] wr_addr;
   logic               wr_ram_en;
   logic [WIDTH_D:0]   wr_gray;
   logic               wr_full;
   logic               wr_almost_full;
   logic [WIDTH_D:0]   wr_level;
   logic               wr_overflow;

   modport master (
      output wr_en, rd_gray_syn, wr_ovf_clr,
      input  wr_addr, wr_ram_en, wr_gray, wr_full, wr_almost_full, wr_level, wr_overflow
   );

   modport slave (
      input  wr_en, rd_gray_syn, wr_ovf_clr,
      output wr_addr, wr_ram_en, wr_gray, wr_full, wr_almost_full, wr_level, wr_overflow
   );
endinterface

// File: rtl/afifo_wr_ctrl.sv
// Write-domain controller of the asynchronous FIFO: binary/Gray write pointers and
// registered full, almost-full, level and sticky overflow against the synced read pointer.
module afifo_wr_ctrl #(
   parameter int WIDTH_D  = 5,
   parameter int AF_LEVEL = 28
) (
   input  logic             wr_clk,
   input  logic             wr_rst,
   afifo_wr_ctrl_if.slave   bus
);
   localparam int W = WIDTH_D;
   localparam logic [W:0] AF_THR = (W+1)'(AF_LEVEL);

   logic [W:0] wbin_reg,  wbin_next;
   logic [W:0] wgray_reg, wgray_next;
   logic [W:0] level_reg, level_next;
   logic [W:0] rbin;
   logic       full_reg,  full_next;
   logic       af_reg,    af_next;
   logic       ovf_reg,   ovf_next;
   logic       acc;

   // Gray to binary: each bit is the XOR of all Gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi <= W; gi = gi + 1) begin : g_gray2bin
         assign rbin[gi] = ^bus.rd_gray_syn[W:gi];
      end
   endgenerate

   always_comb begin
      acc        = bus.wr_en & ~full_reg;
      wbin_next  = wbin_reg + {{W{1'b0}}, acc};
      wgray_next = wbin_next ^ (wbin_next >> 1);
      // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
      full_next  = (wgray_next == {~bus.rd_gray_syn[W:W-1], bus.rd_gray_syn[W-2:0]});
      level_next = wbin_next - rbin;
      af_next    = (level_next >= AF_THR);
      ovf_next   = ovf_reg;
      if (bus.wr_en & full_reg)
         ovf_next = 1'b1;
      else if (bus.wr_ovf_clr)
         ovf_next = 1'b0;
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         wbin_reg  <= '0;
         wgray_reg <= '0;
         level_reg <= '0;
         full_reg  <= 1'b0;
         af_reg    <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         wbin_reg  <= wbin_next;
         wgray_reg <= wgray_next;
         level_reg <= level_next;
         full_reg  <= full_next;
         af_reg    <= af_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign bus.wr_addr        = wbin_reg[W-1:0];
   assign bus.wr_ram_en      = bus.wr_en & ~full_reg;
   assign bus.wr_gray        = wgray_reg;
   assign bus.wr_full        = full_reg;
   assign bus.wr_almost_full = af_reg;
   assign bus.wr_level       = level_reg;
   assign bus.wr_overflow    = ovf_reg;
endmodule
